// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package     : mips_defs
//  Description : Opcode/funct constants, register conventions and small
//                decode helpers shared by the MIPS decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    // Primary opcodes (instr[31:26])
    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [FUNCT_WIDTH-1:0]  FUNCT_JR = 6'h08;

    // Link register written by JAL
    localparam logic [4:0]              REG_RA   = 5'd31;

    // How the raw 16-bit immediate is widened
    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_UPPER = 2'd2
    } imm_kind_e;

    // Logical immediates zero-extend, LUI shifts into the upper half,
    // everything else (arithmetic, memory offsets, branches) sign-extends.
    function automatic imm_kind_e imm_kind(input logic [OPCODE_WIDTH-1:0] opcode);
        imm_kind_e kind;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: kind = IMM_ZERO;
            OP_LUI:                   kind = IMM_UPPER;
            default:                  kind = IMM_SIGN;
        endcase
        return kind;
    endfunction

    // Instructions whose rt field is a source operand (not a destination).
    function automatic logic reads_rt(input logic [OPCODE_WIDTH-1:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

endpackage : mips_defs
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : General-purpose register file, two asynchronous read ports
//                and one synchronous write port. $0 is hard-wired to zero and
//                a write in flight is forwarded to a matching read port.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i       in   1        clock, rising edge
//    rst_ni      in   1        asynchronous reset, active-low (clears storage)
//    we_i        in   1        write enable
//    waddr_i     in   AWIDTH   write address
//    wdata_i     in   DWIDTH   write data
//    raddr_a_i   in   AWIDTH   read port A address
//    raddr_b_i   in   AWIDTH   read port B address
//    rdata_a_o   out  DWIDTH   read port A data
//    rdata_b_o   out  DWIDTH   read port B data
// ============================================================================
module regfile_2r1w #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 32,
    parameter int NUM_REGS = 2**AWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_a_i,
    input  logic [AWIDTH-1:0] raddr_b_i,
    output logic [DWIDTH-1:0] rdata_a_o,
    output logic [DWIDTH-1:0] rdata_b_o
);

    logic [DWIDTH-1:0] mem_q [0:NUM_REGS-1];
    logic              w_wr_valid;

    // Writes to $0 are dropped so the entry stays zero.
    assign w_wr_valid = we_i && (waddr_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_valid) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // $0 rule first, then write-through, then stored value.
    assign rdata_a_o = (raddr_a_i == '0)                     ? '0      :
                       (w_wr_valid && waddr_i == raddr_a_i)  ? wdata_i :
                                                               mem_q[raddr_a_i];

    assign rdata_b_o = (raddr_b_i == '0)                     ? '0      :
                       (w_wr_valid && waddr_i == raddr_b_i)  ? wdata_i :
                                                               mem_q[raddr_b_i];

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pipe
//  Description : MIPS decode stage. One registered stage between fetch and
//                execute: field split, destination resolution, immediate
//                extension, operand read, load-use bubble, stall and flush.
//  Revision    : 1.0 - initial release
//
//  Ports
//    d_clk        in   1        clock, rising edge
//    d_rst        in   1        asynchronous reset, active-low
//    d_i_ce       in   1        instruction valid from fetch
//    d_i_instr    in   IWIDTH   instruction word
//    d_i_stall    in   1        downstream stall, hold all outputs
//    d_i_flush    in   1        kill the instruction being decoded
//    d_i_wb_en    in   1        register-file write enable
//    d_i_wb_addr  in   AWIDTH   writeback address
//    d_i_wb_data  in   DWIDTH   writeback data
//    d_o_ready    out  1        fetch may advance (combinational)
//    d_o_ce       out  1        output bundle valid
//    d_o_opcode   out  6        instr[31:26]
//    d_o_funct    out  6        instr[5:0]
//    d_o_shamt    out  5        instr[10:6]
//    d_o_addr_rs  out  AWIDTH   instr[25:21]
//    d_o_addr_rt  out  AWIDTH   instr[20:16]
//    d_o_addr_rd  out  AWIDTH   resolved destination register
//    d_o_data_rs  out  DWIDTH   rs operand
//    d_o_data_rt  out  DWIDTH   rt operand
//    d_o_imm      out  DWIDTH   extended immediate
//    d_o_wr_reg   out  1        instruction writes a register
//    d_o_mem_rd   out  1        instruction is a load (LW)
// ============================================================================
module decode_pipe
    import mips_defs::*;
#(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 32,
    parameter int IWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int NUM_REGS  = 2**AWIDTH
) (
    input  logic                    d_clk,
    input  logic                    d_rst,
    input  logic                    d_i_ce,
    input  logic [IWIDTH-1:0]       d_i_instr,
    input  logic                    d_i_stall,
    input  logic                    d_i_flush,
    input  logic                    d_i_wb_en,
    input  logic [AWIDTH-1:0]       d_i_wb_addr,
    input  logic [DWIDTH-1:0]       d_i_wb_data,
    output logic                    d_o_ready,
    output logic                    d_o_ce,
    output logic [OPCODE_WIDTH-1:0] d_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  d_o_funct,
    output logic [4:0]              d_o_shamt,
    output logic [AWIDTH-1:0]       d_o_addr_rs,
    output logic [AWIDTH-1:0]       d_o_addr_rt,
    output logic [AWIDTH-1:0]       d_o_addr_rd,
    output logic [DWIDTH-1:0]       d_o_data_rs,
    output logic [DWIDTH-1:0]       d_o_data_rt,
    output logic [DWIDTH-1:0]       d_o_imm,
    output logic                    d_o_wr_reg,
    output logic                    d_o_mem_rd
);

    // ------------------------------------------------------------------
    // Field split
    // ------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [FUNCT_WIDTH-1:0]  w_funct;
    logic [4:0]              w_shamt;
    logic [AWIDTH-1:0]       w_rs;
    logic [AWIDTH-1:0]       w_rt;
    logic [AWIDTH-1:0]       w_rd_field;
    logic [IMM_WIDTH-1:0]    w_imm_raw;

    assign w_opcode   = d_i_instr[31:26];
    assign w_rs       = d_i_instr[25:21];
    assign w_rt       = d_i_instr[20:16];
    assign w_rd_field = d_i_instr[15:11];
    assign w_shamt    = d_i_instr[10:6];
    assign w_funct    = d_i_instr[5:0];
    assign w_imm_raw  = d_i_instr[IMM_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Destination, write-enable and immediate decode
    // ------------------------------------------------------------------
    logic [AWIDTH-1:0] w_dest;
    logic              w_wr_reg;
    logic [DWIDTH-1:0] w_imm_ext;

    always_comb begin
        w_dest = w_rt;
        if (w_opcode == OP_RTYPE) begin
            w_dest = w_rd_field;
        end else if (w_opcode == OP_JAL) begin
            w_dest = AWIDTH'(REG_RA);
        end
    end

    always_comb begin
        w_wr_reg = 1'b0;
        case (w_opcode)
            OP_RTYPE:                          w_wr_reg = (w_funct != FUNCT_JR);
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI,   OP_XORI,
            OP_LUI,  OP_LW,    OP_JAL:         w_wr_reg = 1'b1;
            OP_SW,   OP_BEQ,   OP_BNE, OP_J:   w_wr_reg = 1'b0;
            default:                           w_wr_reg = 1'b0;
        endcase
    end

    always_comb begin
        w_imm_ext = {{(DWIDTH-IMM_WIDTH){w_imm_raw[IMM_WIDTH-1]}}, w_imm_raw};
        case (imm_kind(w_opcode))
            IMM_ZERO:  w_imm_ext = {{(DWIDTH-IMM_WIDTH){1'b0}}, w_imm_raw};
            IMM_UPPER: w_imm_ext = {w_imm_raw, {(DWIDTH-IMM_WIDTH){1'b0}}};
            default:   w_imm_ext = {{(DWIDTH-IMM_WIDTH){w_imm_raw[IMM_WIDTH-1]}}, w_imm_raw};
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] w_rf_rs;
    logic [DWIDTH-1:0] w_rf_rt;

    regfile_2r1w #(
        .AWIDTH   (AWIDTH),
        .DWIDTH   (DWIDTH),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_i     (d_clk),
        .rst_ni    (d_rst),
        .we_i      (d_i_wb_en),
        .waddr_i   (d_i_wb_addr),
        .wdata_i   (d_i_wb_data),
        .raddr_a_i (w_rs),
        .raddr_b_i (w_rt),
        .rdata_a_o (w_rf_rs),
        .rdata_b_o (w_rf_rt)
    );

    // ------------------------------------------------------------------
    // Output stage registers
    // ------------------------------------------------------------------
    logic                    ce_q,      ce_d;
    logic [OPCODE_WIDTH-1:0] opcode_q,  opcode_d;
    logic [FUNCT_WIDTH-1:0]  funct_q,   funct_d;
    logic [4:0]              shamt_q,   shamt_d;
    logic [AWIDTH-1:0]       rs_q,      rs_d;
    logic [AWIDTH-1:0]       rt_q,      rt_d;
    logic [AWIDTH-1:0]       rd_q,      rd_d;
    logic [DWIDTH-1:0]       data_rs_q, data_rs_d;
    logic [DWIDTH-1:0]       data_rt_q, data_rt_d;
    logic [DWIDTH-1:0]       imm_q,     imm_d;
    logic                    wr_reg_q,  wr_reg_d;
    logic                    mem_rd_q,  mem_rd_d;

    // ------------------------------------------------------------------
    // Load-use hazard: the load sitting in the output stage has not yet
    // produced its data, so an instruction that sources its destination
    // must wait one cycle. A load to $0 never creates a dependency.
    // ------------------------------------------------------------------
    logic w_src_match;
    logic w_hazard;
    logic w_kill;
    logic w_load;

    assign w_src_match = (rd_q == w_rs) || (reads_rt(w_opcode) && (rd_q == w_rt));
    assign w_hazard    = ce_q && mem_rd_q && (rd_q != '0) && d_i_ce && w_src_match;

    assign d_o_ready   = !d_i_stall && !w_hazard;

    // Flush wins over everything; a hazard only inserts a bubble when the
    // stage is free to move.
    assign w_kill = d_i_flush || (!d_i_stall && w_hazard);
    assign w_load = !d_i_flush && !d_i_stall && !w_hazard;

    always_comb begin
        ce_d      = ce_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        shamt_d   = shamt_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        data_rs_d = data_rs_q;
        data_rt_d = data_rt_q;
        imm_d     = imm_q;
        wr_reg_d  = wr_reg_q;
        mem_rd_d  = mem_rd_q;

        if (w_kill) begin
            ce_d      = 1'b0;
            opcode_d  = '0;
            funct_d   = '0;
            shamt_d   = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            data_rs_d = '0;
            data_rt_d = '0;
            imm_d     = '0;
            wr_reg_d  = 1'b0;
            mem_rd_d  = 1'b0;
        end else if (w_load) begin
            ce_d      = d_i_ce;
            opcode_d  = w_opcode;
            funct_d   = w_funct;
            shamt_d   = w_shamt;
            rs_d      = w_rs;
            rt_d      = w_rt;
            rd_d      = w_dest;
            data_rs_d = w_rf_rs;
            data_rt_d = w_rf_rt;
            imm_d     = w_imm_ext;
            wr_reg_d  = w_wr_reg;
            mem_rd_d  = (w_opcode == OP_LW);
        end
    end

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            ce_q      <= 1'b0;
            opcode_q  <= '0;
            funct_q   <= '0;
            shamt_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            data_rs_q <= '0;
            data_rt_q <= '0;
            imm_q     <= '0;
            wr_reg_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
        end else begin
            ce_q      <= ce_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            shamt_q   <= shamt_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            data_rs_q <= data_rs_d;
            data_rt_q <= data_rt_d;
            imm_q     <= imm_d;
            wr_reg_q  <= wr_reg_d;
            mem_rd_q  <= mem_rd_d;
        end
    end

    assign d_o_ce      = ce_q;
    assign d_o_opcode  = opcode_q;
    assign d_o_funct   = funct_q;
    assign d_o_shamt   = shamt_q;
    assign d_o_addr_rs = rs_q;
    assign d_o_addr_rt = rt_q;
    assign d_o_addr_rd = rd_q;
    assign d_o_data_rs = data_rs_q;
    assign d_o_data_rt = data_rt_q;
    assign d_o_imm     = imm_q;
    assign d_o_wr_reg  = wr_reg_q;
    assign d_o_mem_rd  = mem_rd_q;

endmodule : decode_pipe
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_pipe
//  Description : Self-checking bench for decode_pipe. Table of instructions
//                with expected decode results, a register-file model for the
//                operands, and a scoreboard queue popped as bundles emerge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

    logic        d_clk = 1'b0;
    logic        d_rst = 1'b0;
    logic        d_i_ce = 1'b0;
    logic [31:0] d_i_instr = '0;
    logic        d_i_stall = 1'b0;
    logic        d_i_flush = 1'b0;
    logic        d_i_wb_en = 1'b0;
    logic [4:0]  d_i_wb_addr = '0;
    logic [31:0] d_i_wb_data = '0;
    logic        d_o_ready;
    logic        d_o_ce;
    logic [5:0]  d_o_opcode;
    logic [5:0]  d_o_funct;
    logic [4:0]  d_o_shamt;
    logic [4:0]  d_o_addr_rs;
    logic [4:0]  d_o_addr_rt;
    logic [4:0]  d_o_addr_rd;
    logic [31:0] d_o_data_rs;
    logic [31:0] d_o_data_rt;
    logic [31:0] d_o_imm;
    logic        d_o_wr_reg;
    logic        d_o_mem_rd;

    decode_pipe dut (
        .d_clk       (d_clk),
        .d_rst       (d_rst),
        .d_i_ce      (d_i_ce),
        .d_i_instr   (d_i_instr),
        .d_i_stall   (d_i_stall),
        .d_i_flush   (d_i_flush),
        .d_i_wb_en   (d_i_wb_en),
        .d_i_wb_addr (d_i_wb_addr),
        .d_i_wb_data (d_i_wb_data),
        .d_o_ready   (d_o_ready),
        .d_o_ce      (d_o_ce),
        .d_o_opcode  (d_o_opcode),
        .d_o_funct   (d_o_funct),
        .d_o_shamt   (d_o_shamt),
        .d_o_addr_rs (d_o_addr_rs),
        .d_o_addr_rt (d_o_addr_rt),
        .d_o_addr_rd (d_o_addr_rd),
        .d_o_data_rs (d_o_data_rs),
        .d_o_data_rt (d_o_data_rt),
        .d_o_imm     (d_o_imm),
        .d_o_wr_reg  (d_o_wr_reg),
        .d_o_mem_rd  (d_o_mem_rd)
    );

    always #5 d_clk = ~d_clk;

    // Vector record: instruction plus the decode results it must produce.
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        wr;
        logic        mr;
    } vec_t;

    // Scoreboard entry: full expected output bundle.
    typedef struct {
        logic [31:0] instr;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] drs;
        logic [31:0] drt;
        logic [31:0] imm;
        logic        wr;
        logic        mr;
    } exp_t;

    int     n_cmp  = 0;
    int     n_fail = 0;
    int     bubbles = 0;
    logic   new_out = 1'b0;
    exp_t   sb[$];
    exp_t   mon_e;
    logic [31:0] rf_m [0:31];
    vec_t   vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register model read as seen by the decode stage (with write-through).
    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (d_i_wb_en && d_i_wb_addr == a) return d_i_wb_data;
        return rf_m[a];
    endfunction

    always @(posedge d_clk) begin
        if (d_rst && d_i_wb_en && d_i_wb_addr != 5'd0)
            rf_m[d_i_wb_addr] = d_i_wb_data;
        new_out = d_rst && !d_i_stall;
    end

    // Output monitor: every fresh valid bundle must match the queue head.
    always @(negedge d_clk) begin
        if (new_out && d_rst) begin
            if (!d_o_ce) begin
                bubbles++;
            end else if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got ce=1 opcode %h, want no output", d_o_opcode);
            end else begin
                mon_e = sb.pop_front();
                chk("opcode",  d_o_opcode,  mon_e.opcode);
                chk("funct",   d_o_funct,   mon_e.funct);
                chk("shamt",   d_o_shamt,   mon_e.shamt);
                chk("addr_rs", d_o_addr_rs, mon_e.rs);
                chk("addr_rt", d_o_addr_rt, mon_e.rt);
                chk("addr_rd", d_o_addr_rd, mon_e.rd);
                chk("data_rs", d_o_data_rs, mon_e.drs);
                chk("data_rt", d_o_data_rt, mon_e.drt);
                chk("imm",     d_o_imm,     mon_e.imm);
                chk("wr_reg",  d_o_wr_reg,  mon_e.wr);
                chk("mem_rd",  d_o_mem_rd,  mon_e.mr);
            end
        end
    end

    // Present one instruction until fetch is allowed to advance. Called at
    // posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, output int tries);
        logic acc;
        exp_t e;
        logic [31:0] ins;
        ins    = v.instr;
        tries  = 0;
        acc    = 1'b0;
        d_i_ce    = 1'b1;
        d_i_instr = ins;
        while (!acc && tries < 8) begin
            @(negedge d_clk);
            acc = d_o_ready;
            if (acc) begin
                e.instr  = ins;
                e.opcode = ins[31:26];
                e.funct  = ins[5:0];
                e.shamt  = ins[10:6];
                e.rs     = ins[25:21];
                e.rt     = ins[20:16];
                e.rd     = v.rd;
                e.drs    = mread(ins[25:21]);
                e.drt    = mread(ins[20:16]);
                e.imm    = v.imm;
                e.wr     = v.wr;
                e.mr     = v.mr;
            end
            @(posedge d_clk);
            #1;
            d_i_wb_en = 1'b0;
            if (acc) sb.push_back(e);
            else     tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance of %h, want accepted within 8 cycles", ins);
        end
        d_i_ce = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        d_i_wb_en   = 1'b1;
        d_i_wb_addr = a;
        d_i_wb_data = d;
        @(posedge d_clk);
        #1;
        d_i_wb_en = 1'b0;
    endtask

    initial begin
        int   t;
        int   b0;
        vec_t v;

        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;

        //              instr          rd     imm            wr    mr
        vecs[0]  = '{32'h00430820, 5'd1,  32'h00000820, 1'b1, 1'b0}; // ADD $1,$2,$3
        vecs[1]  = '{32'h3421F000, 5'd1,  32'h0000F000, 1'b1, 1'b0}; // ORI
        vecs[2]  = '{32'h2021F000, 5'd1,  32'hFFFFF000, 1'b1, 1'b0}; // ADDI
        vecs[3]  = '{32'h3C011234, 5'd1,  32'h12340000, 1'b1, 1'b0}; // LUI
        vecs[4]  = '{32'h30628000, 5'd2,  32'h00008000, 1'b1, 1'b0}; // ANDI
        vecs[5]  = '{32'h24628000, 5'd2,  32'hFFFF8000, 1'b1, 1'b0}; // ADDIU
        vecs[6]  = '{32'h3842FFFF, 5'd2,  32'h0000FFFF, 1'b1, 1'b0}; // XORI
        vecs[7]  = '{32'h2862FFFE, 5'd2,  32'hFFFFFFFE, 1'b1, 1'b0}; // SLTI
        vecs[8]  = '{32'hAC640004, 5'd4,  32'h00000004, 1'b0, 1'b0}; // SW
        vecs[9]  = '{32'h1043FFFF, 5'd3,  32'hFFFFFFFF, 1'b0, 1'b0}; // BEQ
        vecs[10] = '{32'h14430002, 5'd3,  32'h00000002, 1'b0, 1'b0}; // BNE
        vecs[11] = '{32'h08000004, 5'd0,  32'h00000004, 1'b0, 1'b0}; // J
        vecs[12] = '{32'h0C000010, 5'd31, 32'h00000010, 1'b1, 1'b0}; // JAL
        vecs[13] = '{32'h03E00008, 5'd0,  32'h00000008, 1'b0, 1'b0}; // JR $31
        vecs[14] = '{32'hFC220001, 5'd2,  32'h00000001, 1'b0, 1'b0}; // unknown

        // Reset state
        #3;
        chk("rst_ce",      d_o_ce,      0);
        chk("rst_opcode",  d_o_opcode,  0);
        chk("rst_addr_rd", d_o_addr_rd, 0);
        chk("rst_data_rs", d_o_data_rs, 0);
        chk("rst_imm",     d_o_imm,     0);
        chk("rst_wr_reg",  d_o_wr_reg,  0);
        chk("rst_ready",   d_o_ready,   1);
        #9 d_rst = 1'b1;
        @(posedge d_clk); #1;

        wb_write(5'd1,  32'h00000100);
        wb_write(5'd2,  32'h00000005);
        wb_write(5'd3,  32'h00000007);
        wb_write(5'd4,  32'h00000044);
        wb_write(5'd31, 32'h00000ABC);

        // Table-driven decode
        for (int i = 0; i < 15; i++) begin
            send(vecs[i], t);
            chk("table_no_stall", t, 0);
        end

        // Write-through: $6 written in the same cycle AND $7,$6,$6 decodes
        d_i_wb_en = 1'b1; d_i_wb_addr = 5'd6; d_i_wb_data = 32'h0000DEAD;
        v = '{32'h00C63824, 5'd7, 32'h00003824, 1'b1, 1'b0};
        send(v, t);

        // $0 stays zero even after an explicit write
        wb_write(5'd0, 32'h0000FFFF);
        v = '{32'h00004020, 5'd8, 32'h00004020, 1'b1, 1'b0};
        send(v, t);

        // Load-use: LW $4,0($1) then ADD $5,$4,$4 -> one refusal, one bubble
        v = '{32'h8C240000, 5'd4, 32'h00000000, 1'b1, 1'b1};
        send(v, t);
        b0 = bubbles;
        v = '{32'h00842820, 5'd5, 32'h00002820, 1'b1, 1'b0};
        send(v, t);
        chk("hazard_refusals", t, 1);
        chk("hazard_bubbles", bubbles - b0, 1);

        // Load into $0 never stalls a consumer of $0
        v = '{32'h8C200000, 5'd0, 32'h00000000, 1'b1, 1'b1};
        send(v, t);
        v = '{32'h00004020, 5'd8, 32'h00004020, 1'b1, 1'b0};
        send(v, t);
        chk("lw_r0_no_hazard", t, 0);

        // Stall for three edges: outputs frozen on the ADD, ready low
        send(vecs[0], t);
        d_i_stall = 1'b1;
        d_i_ce    = 1'b1;
        d_i_instr = 32'h3421F000;
        for (int k = 0; k < 3; k++) begin
            @(negedge d_clk);
            chk("stall_ready",   d_o_ready,   0);
            chk("stall_ce",      d_o_ce,      1);
            chk("stall_funct",   d_o_funct,   6'h20);
            chk("stall_addr_rd", d_o_addr_rd, 1);
            chk("stall_data_rs", d_o_data_rs, 5);
            @(posedge d_clk); #1;
        end
        d_i_stall = 1'b0;
        send(vecs[1], t);
        chk("post_stall_accept", t, 0);

        // Flush with an ADD on the outputs kills the next bundle
        send(vecs[0], t);
        d_i_flush = 1'b1;
        d_i_ce    = 1'b1;
        d_i_instr = 32'h3421F000;
        @(posedge d_clk); #1;
        d_i_flush = 1'b0;
        d_i_ce    = 1'b0;
        @(negedge d_clk);
        chk("flush_ce", d_o_ce, 0);
        @(posedge d_clk); #1;

        // Asynchronous reset between edges with a valid bundle present
        send(vecs[0], t);
        @(negedge d_clk);
        #2 d_rst = 1'b0;
        #1;
        chk("mid_rst_ce",      d_o_ce,      0);
        chk("mid_rst_opcode",  d_o_opcode,  0);
        chk("mid_rst_funct",   d_o_funct,   0);
        chk("mid_rst_addr_rd", d_o_addr_rd, 0);
        chk("mid_rst_data_rs", d_o_data_rs, 0);
        chk("mid_rst_data_rt", d_o_data_rt, 0);
        chk("mid_rst_imm",     d_o_imm,     0);
        chk("mid_rst_wr_reg",  d_o_wr_reg,  0);
        chk("mid_rst_ready",   d_o_ready,   1);
        chk("mid_rst_sb_empty", sb.size(), 0);
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        @(posedge d_clk);
        #3 d_rst = 1'b1;
        @(posedge d_clk); #1;
        send(vecs[0], t);   // registers now read back as zero

        repeat (3) @(posedge d_clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running, want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_decode_pipe
`default_nettype wire
